// File: rtl/reg_file_loader_if.sv
// -----------------------------------------------------------------------------
// reg_file_loader_if
//
// Groups the byte-stream handshake and the register-file write channel of
// reg_file_loader into one bundle.
//
// Signals:
//   in_valid  producer -> loader   byte on in_data is valid
//   in_ready  loader -> producer   loader can accept a byte this cycle
//   in_data   producer -> loader   8-bit byte
//   wr_en     loader -> reg file   one-cycle word write strobe
//   wr_addr   loader -> reg file   word address (BYTE_ADDR_WIDTH-2 bits)
//   byte_en   loader -> reg file   per-lane write enables
//   wr_data   loader -> reg file   32-bit write data, lane n = bits 8n+7:8n
//
// Modports:
//   slave  - the loader side (consumes the stream, drives the write channel)
//   master - the environment side (drives the stream, observes writes)
//
// BYTE_ADDR_WIDTH must match the parameter of the reg_file_loader that
// this interface is connected to.
// -----------------------------------------------------------------------------
interface reg_file_loader_if #(
  parameter int BYTE_ADDR_WIDTH = 6
);
  logic                       in_valid;
  logic                       in_ready;
  logic [7:0]                 in_data;
  logic                       wr_en;
  logic [BYTE_ADDR_WIDTH-3:0] wr_addr;
  logic [3:0]                 byte_en;
  logic [31:0]                wr_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output byte_en,
    output wr_data
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  byte_en,
    input  wr_data
  );
endinterface

// File: rtl/reg_file_loader.sv
// -----------------------------------------------------------------------------
// reg_file_loader
//
// Loads a run of bytes from a valid/ready byte stream into a 32-bit-wide
// register file. Bytes are packed into word lanes according to their byte
// address; a word write is issued when lane 3 is filled or the last byte of
// the run arrives, so partial first/last words carry only the lanes that
// were actually written. The byte address wraps at 2**BYTE_ADDR_WIDTH.
//
// Parameters:
//   BYTE_ADDR_WIDTH  register file byte-address width (default 6)
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse launching a load (honoured only when idle)
//   start_addr  first byte address of the load
//   start_len   byte count, 0..2**BYTE_ADDR_WIDTH
//   bus         reg_file_loader_if.slave: byte stream in, word writes out
//   busy        high while a load is in progress
//   done        one-cycle completion pulse
//   csum        (only with LOADER_CHECKSUM_EN) XOR of all bytes accepted
//               since the last accepted start; valid while done is high
//
// Configuration macro:
//   LOADER_CHECKSUM_EN  adds the csum output and its accumulator.
// -----------------------------------------------------------------------------
module reg_file_loader #(
  parameter int BYTE_ADDR_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BYTE_ADDR_WIDTH-1:0] start_addr,
  input  logic [BYTE_ADDR_WIDTH:0]   start_len,
  reg_file_loader_if.slave           bus,
  output logic                       busy,
  output logic                       done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]                 csum
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [BYTE_ADDR_WIDTH-1:0] ADDR_ONE = {{(BYTE_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BYTE_ADDR_WIDTH:0]   LEN_ONE  = {{BYTE_ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                     state_reg;
  logic [BYTE_ADDR_WIDTH-1:0] addr_reg;
  logic [BYTE_ADDR_WIDTH:0]   remaining_reg;
  logic                       in_ready_reg;
  logic                       wr_en_reg;
  logic [BYTE_ADDR_WIDTH-3:0] wr_addr_reg;
  logic [3:0]                 byte_en_reg;
  logic [31:0]                wr_data_reg;
  logic                       busy_reg;
  logic                       done_reg;

  logic       accept;
  logic [1:0] lane;

  // in_ready_reg is only ever high in COLLECT, so this is the transfer strobe.
  assign accept = in_ready_reg & bus.in_valid;
  assign lane   = addr_reg[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      in_ready_reg  <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      byte_en_reg   <= '0;
      wr_data_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg      <= start_addr;
            remaining_reg <= start_len;
            byte_en_reg   <= '0;
            wr_data_reg   <= '0;
            busy_reg      <= 1'b1;
            if (start_len != '0) begin
              state_reg    <= COLLECT;
              in_ready_reg <= 1'b1;
            end else begin
              // Empty load: report completion without touching the file.
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (accept) begin
            wr_data_reg[{lane, 3'b000} +: 8] <= bus.in_data;
            byte_en_reg[lane]                <= 1'b1;
            // Word address is taken from the byte being stored, before the
            // increment can carry into the next word.
            wr_addr_reg                      <= addr_reg[BYTE_ADDR_WIDTH-1:2];
            addr_reg                         <= addr_reg + ADDR_ONE;  // wraps naturally
            remaining_reg                    <= remaining_reg - LEN_ONE;
            if (lane == 2'd3 || remaining_reg == LEN_ONE) begin
              state_reg    <= WRITE;
              in_ready_reg <= 1'b0;
              wr_en_reg    <= 1'b1;
            end
          end
        end

        WRITE: begin
          wr_en_reg <= 1'b0;
          if (remaining_reg != '0) begin
            state_reg    <= COLLECT;
            in_ready_reg <= 1'b1;
            byte_en_reg  <= '0;
            wr_data_reg  <= '0;
          end else begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b0;
          wr_en_reg    <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.wr_en    = wr_en_reg;
  assign bus.wr_addr  = wr_addr_reg;
  assign bus.byte_en  = byte_en_reg;
  assign bus.wr_data  = wr_data_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  // Cleared only by a start that is actually honoured (state IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      csum_reg <= '0;
    end else if (accept) begin
      csum_reg <= csum_reg ^ bus.in_data;
    end
  end

  assign csum = csum_reg;
`endif

endmodule

// File: doc/reg_file_loader.md
REG_FILE_LOADER -- requirements
Module: reg_file_loader

Interface
REQ-001 SHALL have parameter BYTE_ADDR_WIDTH, default 6, register file byte-address width (2**BYTE_ADDR_WIDTH bytes, 32-bit words).
REQ-002 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: start  input  1  one-cycle pulse launching a load.
REQ-005 SHALL have ports: start_addr  input  BYTE_ADDR_WIDTH  first byte address of the load.
REQ-006 SHALL have ports: start_len  input  BYTE_ADDR_WIDTH+1  byte count, 0..2**BYTE_ADDR_WIDTH.
REQ-007 SHALL have ports: in_valid  input  1, in_ready  output  1, in_data  input  8  byte stream, valid/ready handshake.
REQ-008 SHALL have ports: wr_en  output  1, wr_addr  output  BYTE_ADDR_WIDTH-2, byte_en  output  4, wr_data  output  32  register-file write channel.
REQ-009 SHALL have ports: busy  output  1  load in progress; done  output  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement FSM IDLE, COLLECT, WRITE, DONE; reset state IDLE.
REQ-011 IDLE: start with start_len>0 -> latch addr/len, go COLLECT; start_len==0 -> DONE, no write; no start -> stay.
REQ-012 start SHALL be ignored in every state except IDLE.
REQ-013 busy SHALL be 1 in COLLECT, WRITE, DONE; 0 in IDLE.
REQ-014 in_ready SHALL be 1 only in COLLECT; transfer occurs when in_valid and in_ready both 1 on a rising edge.
REQ-015 On transfer, in_data SHALL be stored in lane addr[1:0] of wr_data (lane n = bits 8n+7:8n), byte_en[addr[1:0]] set, addr incremented, remaining count decremented.
REQ-016 Byte address SHALL wrap modulo 2**BYTE_ADDR_WIDTH (last byte -> byte 0).
REQ-017 Transfer into lane 3, or transfer of the final byte, SHALL move FSM to WRITE.
REQ-018 WRITE SHALL last exactly one cycle with wr_en=1, wr_addr = word address of collected bytes, byte_en/wr_data = accumulated lanes.
REQ-019 After WRITE: remaining>0 -> COLLECT with byte_en cleared; remaining==0 -> DONE.
REQ-020 DONE SHALL last one cycle with done=1, then IDLE.
REQ-021 wr_en SHALL be 0 outside WRITE; byte_en lanes never written in current word SHALL be 0 (partial first/last words).
REQ-022 Latency: final byte accepted on edge N -> wr_en high cycle N+1, done high cycle N+2.
REQ-023 in_data bytes presented while in_ready=0 SHALL NOT be consumed.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE and all outputs 0 (wr_en, wr_addr, byte_en, wr_data, in_ready, busy, done, checksum).
REQ-025 Reset mid-load SHALL abandon the load; no wr_en pulse for partially collected word after rst_n rises.

Configuration
REQ-026 Macro LOADER_CHECKSUM_EN defined: output csum (8 bits) SHALL hold XOR of all bytes accepted since last start, cleared on accepted start, valid when done=1.
REQ-027 LOADER_CHECKSUM_EN undefined: csum port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 start_addr=0, start_len=4, bytes 11,22,33,44 -> one wr_en, wr_addr=0, byte_en=1111, wr_data=44332211, done 1 cycle later.
REQ-029 start_addr=6, start_len=5, bytes A0..A4 -> writes: addr1 byte_en=1100 data A1A0xxxx; addr2 byte_en=0111 data xxA4A3A2; then done.
REQ-030 start_addr=62 (width 6), start_len=4, bytes 01..04 -> addr15 byte_en=1100, then addr0 byte_en=0011 (wrap).
REQ-031 start_len=0 -> done pulse cycle after start, no wr_en, in_ready stays 0; start during busy ignored.
REQ-032 rst_n low after 2 of 4 bytes accepted -> outputs 0 immediately, no wr_en after release, new load works normally.
REQ-033 LOADER_CHECKSUM_EN defined, bytes 0F,F0,AA -> csum=55 at done; in_valid toggling randomly yields identical writes.
